// File: rtl/i8080_bus_responder.sv
// i8080 bus responder: decodes the status byte the CPU places on the data bus
// during sync and turns the following read/write strobes into memory and I/O
// accesses, with optional wait-state insertion and halt/INTA handling.
module i8080_bus_responder #(
    parameter int              XLEN        = 8,
    parameter int              WAIT_STATES = 0,
    parameter logic [XLEN-1:0] INTA_OPCODE = 8'hFF
) (
    input  logic                clk,
    input  logic                rst_n,
    inout  tri   [XLEN-1:0]     data,
    input  logic [2*XLEN-1:0]   addr,
    input  logic                sync,
    input  logic                dbin,
    input  logic                write_n,
    output logic                ready,
    output logic                halted,
    output logic [2*XLEN-1:0]   mem_addr,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic [XLEN-1:0]     mem_wdata,
    output logic                mem_rd,
    output logic                mem_we,
    output logic [XLEN-1:0]     io_port,
    input  logic [XLEN-1:0]     io_rdata,
    output logic [XLEN-1:0]     io_wdata,
    output logic                io_rd,
    output logic                io_wr,
    output logic                inta_ack
);

    // Status byte bit positions.
    localparam int BIT_INTA  = 0;
    localparam int BIT_WO_N  = 1;
    localparam int BIT_STACK = 2;
    localparam int BIT_HLTA  = 3;
    localparam int BIT_OUT   = 4;
    localparam int BIT_M1    = 5;
    localparam int BIT_INP   = 6;
    localparam int BIT_MEMR  = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        CYC_NONE,
        CYC_INTA,
        CYC_HALT,
        CYC_IO_RD,
        CYC_IO_WR,
        CYC_MEM_RD,
        CYC_MEM_WR
    } cycle_t;

    state_t          state_q;
    state_t          state_d;
    cycle_t          cycle;
    logic [7:0]      status_q;
    logic [3:0]      wait_cnt_q;
    logic            is_read;
    logic            is_write;
    logic            trigger;
    logic            in_access;
    logic            waiting;
    logic            complete;
    logic            halt_done;
    logic            drive_en;
    logic [XLEN-1:0] rd_value;

    // STACK and M1 are latched with the rest of the status but do not
    // influence which kind of access is performed.
    logic unused_status_bits;
    assign unused_status_bits = status_q[BIT_STACK] ^ status_q[BIT_M1];

    // Decode the latched status into a cycle type, highest priority first.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        cycle = CYC_NONE;
        if (status_q[BIT_INTA])       cycle = CYC_INTA;
        else if (status_q[BIT_HLTA])  cycle = CYC_HALT;
        else if (status_q[BIT_INP])   cycle = CYC_IO_RD;
        else if (status_q[BIT_OUT])   cycle = CYC_IO_WR;
        else if (status_q[BIT_MEMR])  cycle = CYC_MEM_RD;
        else if (!status_q[BIT_WO_N]) cycle = CYC_MEM_WR;
    end

    // Access qualifiers: only the strobe that matches the cycle type counts.
    always_comb begin
        is_read   = (cycle == CYC_INTA) || (cycle == CYC_IO_RD) || (cycle == CYC_MEM_RD);
        is_write  = (cycle == CYC_IO_WR) || (cycle == CYC_MEM_WR);
        trigger   = (is_read && dbin) || (is_write && !write_n);
        in_access = (state_q == ST_ACCESS);
        waiting   = in_access && trigger && (wait_cnt_q != 4'd0);
        // A sync on the same edge aborts the cycle, so it never completes.
        complete  = in_access && trigger && (wait_cnt_q == 4'd0) && !sync;
        halt_done = in_access && (cycle == CYC_HALT) && !sync;
    end

    // Next-state logic; a sync restarts the bus cycle from any state.
    always_comb begin
        state_d = state_q;
        if (sync) begin
            state_d = ST_ACCESS;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_IDLE;
                ST_ACCESS: begin
                    if (cycle == CYC_HALT)      state_d = ST_DONE;
                    else if (cycle == CYC_NONE) state_d = ST_IDLE;
                    else if (complete)          state_d = ST_DONE;
                end
                ST_DONE:   if (!dbin && write_n) state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Combinational CPU/peripheral handshakes and read-data selection.
    always_comb begin
        ready    = !waiting;
        mem_rd   = in_access && (cycle == CYC_MEM_RD) && dbin;
        io_rd    = in_access && (cycle == CYC_IO_RD) && dbin;
        drive_en = dbin && is_read && ((state_q == ST_ACCESS) || (state_q == ST_DONE));
        rd_value = '0;
        case (cycle)
            CYC_MEM_RD: rd_value = mem_rdata;
            CYC_IO_RD:  rd_value = io_rdata;
            CYC_INTA:   rd_value = INTA_OPCODE;
            default:    rd_value = '0;
        endcase
    end

    assign data = drive_en ? rd_value : {XLEN{1'bz}};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from before the clock edge.
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Status/address capture and wait-state counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q   <= 8'h00;
            wait_cnt_q <= 4'd0;
            mem_addr   <= '0;
            io_port    <= '0;
        end else if (sync) begin
            status_q   <= data[7:0];
            wait_cnt_q <= 4'(WAIT_STATES);
            mem_addr   <= addr;
            io_port    <= addr[XLEN-1:0];
        end else if (waiting) begin
            // waiting already implies a non-zero count, so this never wraps.
            wait_cnt_q <= wait_cnt_q - 4'd1;
        end
    end

    // One-cycle completion strobes with the write data captured alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            io_wr     <= 1'b0;
            inta_ack  <= 1'b0;
            mem_wdata <= '0;
            io_wdata  <= '0;
        end else begin
            mem_we   <= complete && (cycle == CYC_MEM_WR);
            io_wr    <= complete && (cycle == CYC_IO_WR);
            inta_ack <= complete && (cycle == CYC_INTA);
            if (complete && (cycle == CYC_MEM_WR)) mem_wdata <= data;
            if (complete && (cycle == CYC_IO_WR))  io_wdata  <= data;
        end
    end

    // Halt acknowledge: set by a halt cycle, cleared by a later non-halt sync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         halted <= 1'b0;
        else if (sync && !data[BIT_HLTA])   halted <= 1'b0;
        else if (halt_done)                 halted <= 1'b1;
    end

endmodule
